// File: rtl/usrt_tx_framer_if.sv
// usrt_tx_framer_if: request/data/line bundle between a USRT transmit client
// and the usrt_tx_framer block. The client (master) drives the frame request,
// byte, parity enable, bit-rate enable, flow control and the external frame
// counter; the framer (slave) returns the serial line and handshake status.
interface usrt_tx_framer_if;
   logic       START;
   logic [7:0] din;
   logic       par_en;
   logic       en_usrt;
   logic       RTS;
   logic [5:0] cout;
   logic       max;
   logic       TXD;
   logic       ready;
   logic       busy;
   logic       done;

   modport master (
      output START, din, par_en, en_usrt, RTS, cout, max,
      input  TXD, ready, busy, done
   );

   modport slave (
      input  START, din, par_en, en_usrt, RTS, cout, max,
      output TXD, ready, busy, done
   );
endinterface

// File: rtl/usrt_tx_framer.sv
// usrt_tx_framer: serialises one byte per frame onto TXD as
// start(0), 8 data bits LSB first, optional even-parity bit, stop(1).
// Bit timing comes from an external counter (cout/max) qualified by en_usrt;
// RTS=0 freezes the line and the state.
// Optional feature: define USRT_TX_DBLBUF_EN to add a one-byte holding
// register so a second byte can be queued while a frame is on the line.
module usrt_tx_framer (
   input  logic               clk,
   input  logic               rst,
   usrt_tx_framer_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SEND   = 2'b01,
      FINISH = 2'b10
   } state_t;

   state_t     state_r;
   state_t     state_s;
   logic [7:0] data_r;
   logic       par_en_r;
   logic       parity_r;
   logic       txd_r;
   logic       txd_s;
   logic       ready_r;
   logic       busy_r;
   logic       done_r;
   logic       load_din_s;
   logic       step_s;

`ifdef USRT_TX_DBLBUF_EN
   logic [7:0] hold_data_r;
   logic       hold_par_en_r;
   logic       hold_full_r;
   logic       hold_full_s;
   logic       load_hold_s;
   logic       xfer_hold_s;
`endif

   // Even parity of a byte: the bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

   // Line level for a given bit index; anything outside the frame reads as idle.
   function automatic logic bit_select(input logic [5:0] idx,
                                       input logic [7:0] d,
                                       input logic       pen,
                                       input logic       par);
      logic b;
      case (idx)
         6'd0:    b = 1'b0;
         6'd1:    b = d[0];
         6'd2:    b = d[1];
         6'd3:    b = d[2];
         6'd4:    b = d[3];
         6'd5:    b = d[4];
         6'd6:    b = d[5];
         6'd7:    b = d[6];
         6'd8:    b = d[7];
         6'd9:    b = pen ? par : 1'b1;
         6'd10:   b = 1'b1;
         default: b = 1'b1;
      endcase
      return b;
   endfunction

   assign step_s = bus.en_usrt & bus.RTS;

   // Next-state, line value and load decisions for the framing FSM.
   always_comb begin
      state_s    = state_r;
      txd_s      = txd_r;
      load_din_s = 1'b0;
`ifdef USRT_TX_DBLBUF_EN
      load_hold_s = 1'b0;
      xfer_hold_s = 1'b0;
`endif
      case (state_r)
         IDLE: begin
            // The line stays idle on the accepting edge; the start bit
            // follows the next qualified bit tick.
            txd_s = 1'b1;
            if (bus.START) begin
               load_din_s = 1'b1;
               state_s    = SEND;
            end else begin
               state_s = IDLE;
            end
         end
         SEND: begin
            if (step_s) begin
               txd_s = bit_select(bus.cout, data_r, par_en_r, parity_r);
               if (bus.max) begin
                  state_s = FINISH;
               end else begin
                  state_s = SEND;
               end
            end else begin
               txd_s   = txd_r;
               state_s = SEND;
            end
`ifdef USRT_TX_DBLBUF_EN
            if (bus.START && !hold_full_r) begin
               load_hold_s = 1'b1;
            end else begin
               load_hold_s = 1'b0;
            end
`endif
         end
         FINISH: begin
            txd_s = 1'b1;
`ifdef USRT_TX_DBLBUF_EN
            // A queued byte goes straight back onto the line; with the
            // holding register empty a new request is still accepted here.
            if (hold_full_r) begin
               xfer_hold_s = 1'b1;
               state_s     = SEND;
            end else if (bus.START) begin
               load_din_s = 1'b1;
               state_s    = SEND;
            end else begin
               state_s = IDLE;
            end
`else
            state_s = IDLE;
`endif
         end
         default: begin
            txd_s   = 1'b1;
            state_s = IDLE;
         end
      endcase
   end

`ifdef USRT_TX_DBLBUF_EN
   // Occupancy of the holding register after this edge.
   always_comb begin
      hold_full_s = hold_full_r;
      if (xfer_hold_s) begin
         hold_full_s = 1'b0;
      end else if (load_hold_s) begin
         hold_full_s = 1'b1;
      end else begin
         hold_full_s = hold_full_r;
      end
   end

   // Holding register: one queued byte plus its parity enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_data_r   <= 8'h00;
         hold_par_en_r <= 1'b0;
         hold_full_r   <= 1'b0;
      end else begin
         hold_full_r <= hold_full_s;
         if (load_hold_s) begin
            hold_data_r   <= bus.din;
            hold_par_en_r <= bus.par_en;
         end
      end
   end
`endif

   // Shift data register: loaded from din on an accepted request or from the
   // holding register when a queued byte is promoted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_r   <= 8'h00;
         par_en_r <= 1'b0;
         parity_r <= 1'b0;
      end else if (load_din_s) begin
         data_r   <= bus.din;
         par_en_r <= bus.par_en;
         parity_r <= even_parity(bus.din);
`ifdef USRT_TX_DBLBUF_EN
      end else if (xfer_hold_s) begin
         data_r   <= hold_data_r;
         par_en_r <= hold_par_en_r;
         parity_r <= even_parity(hold_data_r);
`endif
      end
   end

   // State register and registered status/line outputs, all derived from the
   // next state so they line up with the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         txd_r   <= 1'b1;
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         txd_r   <= txd_s;
         busy_r  <= (state_s != IDLE);
         done_r  <= (state_s == FINISH);
`ifdef USRT_TX_DBLBUF_EN
         ready_r <= ~hold_full_s;
`else
         ready_r <= (state_s == IDLE);
`endif
      end
   end

   assign bus.TXD   = txd_r;
   assign bus.ready = ready_r;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;

endmodule

// File: tb/tb_usrt_tx_framer.sv
// tb_usrt_tx_framer: directed self-checking bench for usrt_tx_framer.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_usrt_tx_framer;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   int   done_cnt;

   usrt_tx_framer_if bus ();

   usrt_tx_framer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef USRT_TX_DBLBUF_EN
   localparam logic READY_IN_SEND = 1'b1;
`else
   localparam logic READY_IN_SEND = 1'b0;
`endif

   // Hand-computed line sequences, bit k = TXD after the cout=k tick.
   localparam logic [10:0] EXP_A5    = 11'b111_0100_1010; // A5, no parity
   localparam logic [10:0] EXP_07_P  = 11'b110_0000_1110; // 07, parity 1
   localparam logic [10:0] EXP_03_P  = 11'b100_0000_0110; // 03, parity 0
   localparam logic [10:0] EXP_08    = 11'b110_0001_0000; // 08, no parity

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.done === 1'b1) done_cnt++;
   end

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic [5:0] c, input logic m, input logic e,
                       input logic r, input logic exp, input string tag);
      bus.cout    = c;
      bus.max     = m;
      bus.en_usrt = e;
      bus.RTS     = r;
      tick();
      chk(32'(bus.TXD), 32'(exp), tag);
   endtask

   // Request a frame with en_usrt high on the same edge: the line must stay idle.
   task automatic start_frame(input logic [7:0] d, input logic p, input string tag);
      bus.START   = 1'b1;
      bus.din     = d;
      bus.par_en  = p;
      bus.en_usrt = 1'b1;
      bus.RTS     = 1'b1;
      bus.cout    = 6'd0;
      bus.max     = 1'b0;
      tick();
      bus.START   = 1'b0;
      chk(32'(bus.TXD),   32'd1, {tag, "_idle_on_accept"});
      chk(32'(bus.busy),  32'd1, {tag, "_busy"});
      chk(32'(bus.ready), 32'(READY_IN_SEND), {tag, "_ready"});
   endtask

   task automatic run_bits(input logic [10:0] exp, input int from, input int to,
                           input string tag);
      for (int k = from; k <= to; k++) begin
         step(6'(k), (k == 10), 1'b1, 1'b1, exp[k], $sformatf("%s_b%0d", tag, k));
      end
   endtask

   // After the cout=10 tick: done for one clk, then back to idle.
   task automatic finish_check(input int exp_done, input string tag);
      chk(32'(bus.done), 32'd1, {tag, "_done_hi"});
      bus.en_usrt = 1'b0;
      bus.max     = 1'b0;
      tick();
      chk(32'(bus.done),  32'd0, {tag, "_done_lo"});
      chk(32'(bus.busy),  32'd0, {tag, "_idle_busy"});
      chk(32'(bus.ready), 32'd1, {tag, "_idle_ready"});
      chk(32'(bus.TXD),   32'd1, {tag, "_idle_txd"});
      chk(32'(done_cnt),  32'(exp_done), {tag, "_done_count"});
   endtask

   initial begin
      errors      = 0;
      checks      = 0;
      done_cnt    = 0;
      rst         = 1'b0;
      bus.START   = 1'b0;
      bus.din     = 8'h00;
      bus.par_en  = 1'b0;
      bus.en_usrt = 1'b0;
      bus.RTS     = 1'b1;
      bus.cout    = 6'd0;
      bus.max     = 1'b0;

      // Asynchronous reset, checked before any clock edge.
      #2 rst = 1'b1;
      #1;
      chk(32'(bus.TXD),   32'd1, "rst_txd");
      chk(32'(bus.ready), 32'd1, "rst_ready");
      chk(32'(bus.busy),  32'd0, "rst_busy");
      chk(32'(bus.done),  32'd0, "rst_done");
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk(32'(bus.TXD), 32'd1, "idle_txd");

      // Basic frame A5, no parity.
      start_frame(8'hA5, 1'b0, "a5");
      run_bits(EXP_A5, 0, 10, "a5");
      finish_check(1, "a5");

      // Parity: odd ones count -> 1, even -> 0.
      start_frame(8'h07, 1'b1, "p07");
      run_bits(EXP_07_P, 0, 10, "p07");
      finish_check(2, "p07");
      start_frame(8'h03, 1'b1, "p03");
      run_bits(EXP_03_P, 0, 10, "p03");
      finish_check(3, "p03");

      // RTS stall at cout=4: line holds din[3] while en_usrt keeps ticking.
      start_frame(8'h08, 1'b0, "rts");
      run_bits(EXP_08, 0, 4, "rts");
      for (int k = 0; k < 5; k++) begin
         step(6'(5 + k), 1'b0, 1'b1, 1'b0, 1'b1, $sformatf("rts_hold%0d", k));
         chk(32'(bus.busy), 32'd1, $sformatf("rts_hold_busy%0d", k));
      end
      run_bits(EXP_08, 5, 10, "rts_resume");
      finish_check(4, "rts");

      // Reset mid-frame while cout=6 is presented: abort, no done.
      start_frame(8'hA5, 1'b0, "mid");
      run_bits(EXP_A5, 0, 5, "mid");
      bus.cout    = 6'd6;
      bus.en_usrt = 1'b0;
      chk(32'(bus.TXD), 32'd0, "mid_pre_rst_txd");
      #2 rst = 1'b1;
      #1;
      chk(32'(bus.TXD),  32'd1, "mid_rst_txd");
      chk(32'(bus.busy), 32'd0, "mid_rst_busy");
      chk(32'(bus.done), 32'd0, "mid_rst_done");
      tick();
      rst = 1'b0;
      tick();
      chk(32'(done_cnt), 32'd4, "mid_no_done");
      start_frame(8'hA5, 1'b0, "post");
      run_bits(EXP_A5, 0, 10, "post");
      finish_check(5, "post");

      // START pulsed during SEND.
      start_frame(8'hA5, 1'b0, "busy_start");
      run_bits(EXP_A5, 0, 3, "busy_start");
      bus.START   = 1'b1;
      bus.din     = 8'hFF;
      bus.par_en  = 1'b1;
      bus.en_usrt = 1'b0;
      tick();
      bus.START   = 1'b0;
      chk(32'(bus.ready), 32'd0, "busy_start_ready");
      run_bits(EXP_A5, 4, 10, "busy_start");
`ifdef USRT_TX_DBLBUF_EN
      chk(32'(bus.done), 32'd1, "dbl_done1");
      bus.en_usrt = 1'b0;
      bus.max     = 1'b0;
      tick();
      chk(32'(bus.busy), 32'd1, "dbl_backtoback_busy");
      run_bits(11'b101_1111_1110, 0, 10, "dbl_ff");
      finish_check(7, "dbl");
`else
      finish_check(6, "busy_start");
      tick();
      chk(32'(bus.busy), 32'd0, "busy_start_ignored");
      chk(32'(done_cnt), 32'd6, "busy_start_no_extra");
`endif

      // Out-of-range bit index in SEND drives idle level.
      start_frame(8'hA5, 1'b0, "c15");
      run_bits(EXP_A5, 0, 2, "c15");
      step(6'd15, 1'b0, 1'b1, 1'b1, 1'b1, "c15_txd");
      run_bits(EXP_A5, 3, 10, "c15");
`ifdef USRT_TX_DBLBUF_EN
      finish_check(8, "c15");
`else
      finish_check(7, "c15");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
